cpu_datapath: RTL and testbench

- 32-bit register-transfer datapath for the teaching CPU.
- A single shared bus is driven by one source selected by an encoded code.
- Registers load from the bus, or the MDR loads from memory, when an encoded enable code selects them.
- An ALU combines Y with the bus into a 64-bit Z register.
- The external control unit or testbench sequences the micro-steps; this block holds no FSM.

---
 rtl/datapath_pkg.sv | 61 ++++++
 rtl/datapath_alu.sv | 84 ++++++++
 rtl/cpu_datapath.sv | 150 +++++++++++++++
 tb/tb_cpu_datapath.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/datapath_pkg.sv
// -----------------------------------------------------------------------------
// datapath_pkg
//   Shared definitions for the teaching-CPU register-transfer datapath:
//     - load-target (enable) codes decoded from the low five bits of `enable`
//     - bus-source (select) codes decoded from the low five bits of `busSelect`
//     - the ALU operation encoding driven on `Control_Signals`
//   Ports: none (package).
// -----------------------------------------------------------------------------
package datapath_pkg;

    // Width of the decoded part of the enable / bus-select words.
    localparam int CODE_W = 5;

    // Codes 1..15 address R1..R15 directly; R0 sits at 16 so that 0 means "none".
    localparam logic [CODE_W-1:0] GPR_LAST   = 5'd15;

    // Load-target codes (26..31 are unused and load nothing).
    localparam logic [CODE_W-1:0] EN_NONE    = 5'd0;
    localparam logic [CODE_W-1:0] EN_R0      = 5'd16;
    localparam logic [CODE_W-1:0] EN_HI      = 5'd17;
    localparam logic [CODE_W-1:0] EN_LO      = 5'd18;
    localparam logic [CODE_W-1:0] EN_Y       = 5'd19;
    localparam logic [CODE_W-1:0] EN_PC      = 5'd20;
    localparam logic [CODE_W-1:0] EN_MDR     = 5'd21;
    localparam logic [CODE_W-1:0] EN_OUTPORT = 5'd22;
    localparam logic [CODE_W-1:0] EN_IR      = 5'd23;
    localparam logic [CODE_W-1:0] EN_Z       = 5'd24;
    localparam logic [CODE_W-1:0] EN_MAR     = 5'd25;

    // Bus-source codes (24..31 drive zero).
    localparam logic [CODE_W-1:0] SEL_ZERO   = 5'd0;
    localparam logic [CODE_W-1:0] SEL_R0     = 5'd16;
    localparam logic [CODE_W-1:0] SEL_HI     = 5'd17;
    localparam logic [CODE_W-1:0] SEL_ZLO    = 5'd18;
    localparam logic [CODE_W-1:0] SEL_ZHI    = 5'd19;
    localparam logic [CODE_W-1:0] SEL_PC     = 5'd20;
    localparam logic [CODE_W-1:0] SEL_MDR    = 5'd21;
    localparam logic [CODE_W-1:0] SEL_INPORT = 5'd22;
    localparam logic [CODE_W-1:0] SEL_LO     = 5'd23;

    // ALU operations; the encoding is the value driven on Control_Signals.
    typedef enum logic [3:0] {
        OP_ADD    = 4'b0000,
        OP_SUB    = 4'b0001,
        OP_AND    = 4'b0010,
        OP_OR     = 4'b0011,
        OP_SHR    = 4'b0100,
        OP_SHRA   = 4'b0101,
        OP_SHL    = 4'b0110,
        OP_ROR    = 4'b0111,
        OP_ROL    = 4'b1000,
        OP_NEG    = 4'b1001,
        OP_NOT    = 4'b1010,
        OP_MUL    = 4'b1011,
        OP_DIV    = 4'b1100,
        OP_INCPC  = 4'b1101,
        OP_PASS_E = 4'b1110,
        OP_PASS_F = 4'b1111
    } alu_op_e;

endpackage

// File: rtl/datapath_alu.sv
// -----------------------------------------------------------------------------
// datapath_alu
//   Purely combinational ALU. A is the Y register, B is the shared bus.
//   Single-width results land in [WIDTH-1:0] with the upper half zero; MUL
//   fills all 2*WIDTH bits, DIV puts the quotient low and the remainder high.
//   Ports:
//     i_a      in  WIDTH    operand A (Y)
//     i_b      in  WIDTH    operand B (bus)
//     i_op     in  4        operation (alu_op_e)
//     o_result out 2*WIDTH  result written into Z
// -----------------------------------------------------------------------------
module datapath_alu
    import datapath_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0]   i_a,
    input  logic [WIDTH-1:0]   i_b,
    input  alu_op_e            i_op,
    output logic [2*WIDTH-1:0] o_result
);

    localparam int                 SHW   = $clog2(WIDTH);
    localparam logic [SHW:0]       W_LIT = SHW'(0) + (SHW+1)'(WIDTH);
    localparam logic [WIDTH-1:0]   ONE   = WIDTH'(1);

    logic [SHW-1:0]            w_shamt;
    logic [SHW:0]              w_shamt_inv;
    logic signed [WIDTH-1:0]   w_sa;
    logic signed [WIDTH-1:0]   w_sb;
    logic signed [2*WIDTH-1:0] w_sa_ext;
    logic signed [2*WIDTH-1:0] w_sb_ext;
    logic signed [2*WIDTH-1:0] w_prod;
    logic signed [WIDTH-1:0]   w_quot;
    logic signed [WIDTH-1:0]   w_rem;

    assign w_shamt     = i_b[SHW-1:0];
    // For a zero amount this is WIDTH, and a shift by WIDTH yields zero, so
    // the rotates below collapse to plain A without a special case.
    assign w_shamt_inv = W_LIT - {1'b0, w_shamt};

    assign w_sa     = $signed(i_a);
    assign w_sb     = $signed(i_b);
    // Sign-extend to full width first so the product is the exact signed
    // 2*WIDTH-bit result rather than a truncated single-width one.
    assign w_sa_ext = {{WIDTH{i_a[WIDTH-1]}}, i_a};
    assign w_sb_ext = {{WIDTH{i_b[WIDTH-1]}}, i_b};
    assign w_prod   = w_sa_ext * w_sb_ext;

    // Signed / and % truncate toward zero, so the remainder follows the
    // dividend's sign. The zero-divisor case is overridden below.
    assign w_quot   = w_sa / w_sb;
    assign w_rem    = w_sa % w_sb;

    // NOTE: every output of a combinational block gets a default before the
    // case so that no path leaves it unassigned and infers a latch.
    always_comb begin
        o_result = '0;
        case (i_op)
            OP_ADD:   o_result[WIDTH-1:0] = i_a + i_b;
            OP_SUB:   o_result[WIDTH-1:0] = i_a - i_b;
            OP_AND:   o_result[WIDTH-1:0] = i_a & i_b;
            OP_OR:    o_result[WIDTH-1:0] = i_a | i_b;
            OP_SHR:   o_result[WIDTH-1:0] = i_a >> w_shamt;
            OP_SHRA:  o_result[WIDTH-1:0] = w_sa >>> w_shamt;
            OP_SHL:   o_result[WIDTH-1:0] = i_a << w_shamt;
            OP_ROR:   o_result[WIDTH-1:0] = (i_a >> w_shamt) | (i_a << w_shamt_inv);
            OP_ROL:   o_result[WIDTH-1:0] = (i_a << w_shamt) | (i_a >> w_shamt_inv);
            OP_NEG:   o_result[WIDTH-1:0] = '0 - i_b;
            OP_NOT:   o_result[WIDTH-1:0] = ~i_b;
            OP_MUL:   o_result            = w_prod;
            OP_DIV: begin
                if (i_b == '0) begin
                    o_result = {i_a, {WIDTH{1'b1}}};
                end else begin
                    o_result = {w_rem, w_quot};
                end
            end
            OP_INCPC: o_result[WIDTH-1:0] = i_b + ONE;
            default:  o_result[WIDTH-1:0] = i_b;
        endcase
    end

endmodule

// File: rtl/cpu_datapath.sv
// -----------------------------------------------------------------------------
// cpu_datapath
//   32-bit register-transfer datapath for the teaching CPU. One shared bus is
//   driven by the source chosen with busSelect; at most one register loads per
//   clock, chosen with enable. The control unit outside sequences the steps.
//   Ports:
//     clk             in  1      rising-edge clock
//     clr             in  1      synchronous active-high clear of all registers
//     enable          in  32     load-target code ([4:0] decoded, [31:5]!=0 -> none)
//     busSelect       in  32     bus-source code ([4:0] decoded, [31:5]!=0 -> 0)
//     inPort          in  WIDTH  external input-port value
//     MDataIn         in  WIDTH  memory read data
//     MD_Read         in  1      MDR source: 1 = MDataIn, 0 = bus
//     Control_Signals in  4      ALU operation (alu_op_e encoding)
//     busMuxOut       out WIDTH  current bus value (combinational)
//     o_outport       out WIDTH  OutPort register, drives the external output port
//     o_ir            out WIDTH  IR register, feeds the control unit's decoder
//     o_mar           out WIDTH  MAR register, drives the memory address
// -----------------------------------------------------------------------------
module cpu_datapath
    import datapath_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [31:0]      enable,
    input  logic [31:0]      busSelect,
    input  logic [WIDTH-1:0] inPort,
    input  logic [WIDTH-1:0] MDataIn,
    input  logic             MD_Read,
    input  logic [3:0]       Control_Signals,
    output logic [WIDTH-1:0] busMuxOut,
    output logic [WIDTH-1:0] o_outport,
    output logic [WIDTH-1:0] o_ir,
    output logic [WIDTH-1:0] o_mar
);

    localparam int NUM_GPR = 16;

    // Architectural registers.
    logic [WIDTH-1:0]   r_gpr [NUM_GPR];
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic [WIDTH-1:0]   r_y;
    logic [WIDTH-1:0]   r_pc;
    logic [WIDTH-1:0]   r_mdr;
    logic [WIDTH-1:0]   r_ir;
    logic [WIDTH-1:0]   r_mar;
    logic [WIDTH-1:0]   r_outport;
    logic [2*WIDTH-1:0] r_z;

    // Decoded control codes. A code with any upper bit set is treated as
    // invalid as a whole rather than aliasing onto its low five bits.
    logic              w_en_valid;
    logic [CODE_W-1:0] w_en_code;
    logic              w_sel_valid;
    logic [CODE_W-1:0] w_sel_code;

    logic [WIDTH-1:0]   w_bus;
    logic [WIDTH-1:0]   w_mdr_in;
    logic [2*WIDTH-1:0] w_alu_result;

    assign w_en_valid  = ~|enable[31:CODE_W];
    assign w_en_code   = enable[CODE_W-1:0];
    assign w_sel_valid = ~|busSelect[31:CODE_W];
    assign w_sel_code  = busSelect[CODE_W-1:0];

    // ---------------------------------------------------------------- bus mux
    always_comb begin
        w_bus = '0;
        if (w_sel_valid) begin
            if (w_sel_code != SEL_ZERO && w_sel_code <= GPR_LAST) begin
                w_bus = r_gpr[w_sel_code[3:0]];
            end else begin
                case (w_sel_code)
                    SEL_R0:     w_bus = r_gpr[0];
                    SEL_HI:     w_bus = r_hi;
                    SEL_ZLO:    w_bus = r_z[WIDTH-1:0];
                    SEL_ZHI:    w_bus = r_z[2*WIDTH-1:WIDTH];
                    SEL_PC:     w_bus = r_pc;
                    SEL_MDR:    w_bus = r_mdr;
                    SEL_INPORT: w_bus = inPort;
                    SEL_LO:     w_bus = r_lo;
                    default:    w_bus = '0;
                endcase
            end
        end
    end

    assign busMuxOut = w_bus;

    // ------------------------------------------------------------- MDR source
    assign w_mdr_in = MD_Read ? MDataIn : w_bus;

    // -------------------------------------------------------------------- ALU
    datapath_alu #(
        .WIDTH    (WIDTH)
    ) u_alu (
        .i_a      (r_y),
        .i_b      (w_bus),
        .i_op     (alu_op_e'(Control_Signals)),
        .o_result (w_alu_result)
    );

    // --------------------------------------------------------- register loads
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge bus, regardless of statement order in this block.
    always_ff @(posedge clk) begin
        if (clr) begin
            // NOTE: the register file is a bank of flops, not a RAM macro, so
            // clearing every entry on reset is legitimate and is required here.
            for (int i = 0; i < NUM_GPR; i++) begin
                r_gpr[i] <= '0;
            end
            r_hi      <= '0;
            r_lo      <= '0;
            r_y       <= '0;
            r_pc      <= '0;
            r_mdr     <= '0;
            r_ir      <= '0;
            r_mar     <= '0;
            r_outport <= '0;
            r_z       <= '0;
        end else if (w_en_valid) begin
            if (w_en_code != EN_NONE && w_en_code <= GPR_LAST) begin
                r_gpr[w_en_code[3:0]] <= w_bus;
            end else begin
                case (w_en_code)
                    EN_R0:      r_gpr[0]  <= w_bus;
                    EN_HI:      r_hi      <= w_bus;
                    EN_LO:      r_lo      <= w_bus;
                    EN_Y:       r_y       <= w_bus;
                    EN_PC:      r_pc      <= w_bus;
                    EN_MDR:     r_mdr     <= w_mdr_in;
                    EN_OUTPORT: r_outport <= w_bus;
                    EN_IR:      r_ir      <= w_bus;
                    EN_Z:       r_z       <= w_alu_result;
                    EN_MAR:     r_mar     <= w_bus;
                    default:    ;
                endcase
            end
        end
    end

    assign o_outport = r_outport;
    assign o_ir      = r_ir;
    assign o_mar     = r_mar;

endmodule

// File: tb/tb_cpu_datapath.sv
// -----------------------------------------------------------------------------
// tb_cpu_datapath
//   Self-checking bench for cpu_datapath: directed micro-step sequences plus a
//   randomized phase, all compared against a behavioural model of the
//   register set and ALU kept in this file.
// -----------------------------------------------------------------------------
module tb_cpu_datapath;

    logic        clk = 1'b0;
    logic        clr;
    logic [31:0] enable;
    logic [31:0] busSelect;
    logic [31:0] inPort;
    logic [31:0] MDataIn;
    logic        MD_Read;
    logic [3:0]  Control_Signals;
    logic [31:0] busMuxOut;
    logic [31:0] o_outport;
    logic [31:0] o_ir;
    logic [31:0] o_mar;

    always #5 clk = ~clk;

    cpu_datapath #(.WIDTH(32)) dut (
        .clk             (clk),
        .clr             (clr),
        .enable          (enable),
        .busSelect       (busSelect),
        .inPort          (inPort),
        .MDataIn         (MDataIn),
        .MD_Read         (MD_Read),
        .Control_Signals (Control_Signals),
        .busMuxOut       (busMuxOut),
        .o_outport       (o_outport),
        .o_ir            (o_ir),
        .o_mar           (o_mar)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // ------------------------------------------------------- reference model
    logic [31:0] m_gpr [16];
    logic [31:0] m_hi, m_lo, m_y, m_pc, m_mdr, m_ir, m_mar, m_out;
    logic [63:0] m_z;

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_gpr[i] = '0;
        m_hi = '0; m_lo = '0; m_y = '0; m_pc = '0; m_mdr = '0;
        m_ir = '0; m_mar = '0; m_out = '0; m_z = '0;
    endtask

    function automatic logic [31:0] ref_bus(input logic [31:0] sel, input logic [31:0] inp);
        int code;
        if (sel > 32'd31) return '0;
        code = int'(sel);
        if (code >= 1 && code <= 15) return m_gpr[code];
        case (code)
            16: return m_gpr[0];
            17: return m_hi;
            18: return m_z[31:0];
            19: return m_z[63:32];
            20: return m_pc;
            21: return m_mdr;
            22: return inp;
            23: return m_lo;
            default: return '0;
        endcase
    endfunction

    function automatic logic [63:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                            input logic [3:0] op);
        int          n;
        longint      sa, sb;
        logic [31:0] lo;
        n  = int'(b[4:0]);
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            4'd0:  lo = a + b;
            4'd1:  lo = a - b;
            4'd2:  lo = a & b;
            4'd3:  lo = a | b;
            4'd4:  lo = a >> n;
            4'd5:  lo = 32'(sa >>> n);
            4'd6:  lo = a << n;
            4'd7:  lo = (n == 0) ? a : ((a >> n) | (a << (32 - n)));
            4'd8:  lo = (n == 0) ? a : ((a << n) | (a >> (32 - n)));
            4'd9:  lo = 32'(0 - sb);
            4'd10: lo = ~b;
            4'd11: return 64'(sa * sb);
            4'd12: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                return {32'(sa % sb), 32'(sa / sb)};
            end
            4'd13: lo = b + 32'd1;
            default: lo = b;
        endcase
        return {32'h0, lo};
    endfunction

    task automatic model_edge(input logic [31:0] en, input logic [31:0] bus,
                              input logic rd, input logic [31:0] mdata, input logic [3:0] op);
        int code;
        if (en > 32'd31) return;
        code = int'(en);
        if (code >= 1 && code <= 15) begin
            m_gpr[code] = bus;
            return;
        end
        case (code)
            16: m_gpr[0] = bus;
            17: m_hi  = bus;
            18: m_lo  = bus;
            19: m_y   = bus;
            20: m_pc  = bus;
            21: m_mdr = rd ? mdata : bus;
            22: m_out = bus;
            23: m_ir  = bus;
            24: m_z   = ref_alu(m_y, bus, op);
            25: m_mar = bus;
            default: ;
        endcase
    endtask

    // ------------------------------------------------------------- stimulus
    // One micro-step: drive at the falling edge, check the bus, let the
    // rising edge load, then check the externally visible registers.
    task automatic cycle(input logic [31:0] en, input logic [31:0] sel,
                         input logic [31:0] inp = 32'h0, input logic [3:0] op = 4'h0,
                         input logic rd = 1'b0, input logic [31:0] mdata = 32'h0);
        logic [31:0] exp_bus;
        @(negedge clk);
        clr = 1'b0; enable = en; busSelect = sel; inPort = inp;
        Control_Signals = op; MD_Read = rd; MDataIn = mdata;
        #1;
        exp_bus = ref_bus(sel, inp);
        check("bus", busMuxOut, exp_bus);
        model_edge(en, exp_bus, rd, mdata, op);
        @(posedge clk);
        #1;
        enable = 32'h0;
        check("outport", o_outport, m_out);
        check("ir", o_ir, m_ir);
        check("mar", o_mar, m_mar);
    endtask

    task automatic peek(input string tag, input logic [31:0] sel, input logic [31:0] exp);
        @(negedge clk);
        enable = 32'h0; busSelect = sel;
        #1;
        check(tag, busMuxOut, exp);
    endtask

    // Clear with a load request pending in the same cycle; clear must win.
    task automatic reset_pulse(input logic [31:0] en, input logic [31:0] sel, input logic [31:0] inp);
        @(negedge clk);
        clr = 1'b1; enable = en; busSelect = sel; inPort = inp;
        @(posedge clk);
        model_reset();
        #1;
        enable = 32'h0; busSelect = 32'd2;
        #1;
        check("clr_held_bus", busMuxOut, 32'h0);
        @(negedge clk);
        clr = 1'b0;
    endtask

    initial begin
        logic [31:0] en, sel;
        clr = 1'b1; enable = '0; busSelect = '0; inPort = '0;
        MDataIn = '0; MD_Read = 1'b0; Control_Signals = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_bus_zhi", busMuxOut, 32'h0);
        @(negedge clk);
        clr = 1'b0;

        // Reset: preload R2, then clear with enable=2 pending.
        cycle(32'd2, 32'd22, 32'd5);
        peek("r2_preload", 32'd2, 32'd5);
        reset_pulse(32'd2, 32'd22, 32'h77);
        peek("r2_after_clr", 32'd2, 32'h0);
        check("ir_after_clr", o_ir, 32'h0);

        // MDR path from memory, then onward into GPRs.
        cycle(32'd21, 32'd0, 32'h0, 4'h0, 1'b1, 32'h12);
        peek("mdr_12", 32'd21, 32'h12);
        cycle(32'd2, 32'd21);
        peek("r2_12", 32'd2, 32'h12);
        cycle(32'd21, 32'd0, 32'h0, 4'h0, 1'b1, 32'h14);
        cycle(32'd3, 32'd21);
        peek("r3_14", 32'd3, 32'h14);
        cycle(32'd21, 32'd0, 32'h0, 4'h0, 1'b1, 32'h18);
        cycle(32'd1, 32'd21);
        peek("r1_18", 32'd1, 32'h18);
        // MD_Read=0 takes the bus instead.
        cycle(32'd21, 32'd22, 32'hCAFE, 4'h0, 1'b0, 32'h99);
        peek("mdr_from_bus", 32'd21, 32'hCAFE);

        // SHRA into Z, then Z low into R0.
        cycle(32'd2, 32'd22, 32'h8000_0010);
        cycle(32'd19, 32'd2);
        cycle(32'd3, 32'd22, 32'd4);
        cycle(32'd24, 32'd3, 32'h0, 4'b0101);
        peek("shra_zlo", 32'd18, 32'hF800_0001);
        peek("shra_zhi", 32'd19, 32'h0);
        cycle(32'd16, 32'd18);
        peek("r0_shra", 32'd16, 32'hF800_0001);

        // PC increment through Z.
        cycle(32'd20, 32'd22, 32'h0);
        cycle(32'd24, 32'd20, 32'h0, 4'b1101);
        peek("incpc_zlo", 32'd18, 32'd1);
        cycle(32'd20, 32'd18);
        peek("pc_1", 32'd20, 32'd1);

        // MUL and DIV, including divide by zero and a negative dividend.
        cycle(32'd19, 32'd22, 32'hFFFF_FFFF);
        cycle(32'd24, 32'd22, 32'd2, 4'b1011);
        peek("mul_zhi", 32'd19, 32'hFFFF_FFFF);
        peek("mul_zlo", 32'd18, 32'hFFFF_FFFE);
        cycle(32'd19, 32'd22, 32'h14);
        cycle(32'd24, 32'd22, 32'd3, 4'b1100);
        peek("div_zlo", 32'd18, 32'd6);
        peek("div_zhi", 32'd19, 32'd2);
        cycle(32'd19, 32'd22, 32'd7);
        cycle(32'd24, 32'd0, 32'h0, 4'b1100);
        peek("div0_zlo", 32'd18, 32'hFFFF_FFFF);
        peek("div0_zhi", 32'd19, 32'd7);
        cycle(32'd19, 32'd22, 32'hFFFF_FFF9);
        cycle(32'd24, 32'd22, 32'd2, 4'b1100);
        peek("divneg_zlo", 32'd18, 32'hFFFF_FFFD);
        peek("divneg_zhi", 32'd19, 32'hFFFF_FFFF);

        // Rotates: amount 0 returns A, nonzero wraps bits around.
        cycle(32'd19, 32'd22, 32'h1234_5678);
        cycle(32'd24, 32'd0, 32'h0, 4'b0111);
        peek("ror0", 32'd18, 32'h1234_5678);
        cycle(32'd24, 32'd22, 32'd4, 4'b0111);
        peek("ror4", 32'd18, 32'h8123_4567);
        cycle(32'd24, 32'd22, 32'd8, 4'b1000);
        peek("rol8", 32'd18, 32'h3456_7812);

        // Unused codes and out-of-range upper bits have no effect.
        cycle(32'd30, 32'd28, 32'h5555_AAAA);
        peek("sel_unused", 32'd28, 32'h0);
        cycle(32'h0000_0022, 32'd22, 32'hDEAD_BEEF);
        peek("en_upper_bits", 32'd2, 32'h8000_0010);
        peek("sel_upper_bits", 32'h0000_0102, 32'h0);
        for (int s = 1; s <= 23; s++) peek("sweep_unused", 32'(s), ref_bus(32'(s), inPort));

        // IR loads from the bus.
        cycle(32'd23, 32'd22, 32'h4009_0000);
        check("ir_load", o_ir, 32'h4009_0000);

        // Randomized phase against the model.
        for (int k = 0; k < 500; k++) begin
            if ($urandom_range(0, 59) == 0) begin
                reset_pulse($urandom_range(0, 31), 32'd22, $urandom);
            end else begin
                en  = 32'($urandom_range(0, 31));
                if ($urandom_range(0, 3) == 0) en = 32'd24;
                if ($urandom_range(0, 7) == 0) en = 32'd19;
                if ($urandom_range(0, 15) == 0) en = en | (32'h1 << $urandom_range(5, 31));
                sel = 32'($urandom_range(0, 31));
                if ($urandom_range(0, 15) == 0) sel = sel | (32'h1 << $urandom_range(5, 31));
                cycle(en, sel, $urandom, 4'($urandom_range(0, 15)),
                      1'($urandom_range(0, 1)), $urandom);
            end
        end
        for (int s = 0; s < 32; s++) peek("final_sweep", 32'(s), ref_bus(32'(s), inPort));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
